// File: rtl/ahb_slave_mem_if.sv
// AHB bus bundle between the master and the memory-backed slave.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// Memory-backed AHB slave: 1 + WAIT_STATES data-phase cycles, two-cycle ERROR for illegal accesses.
// Optional AHB_SLAVE_BURST_CHECK_EN validates SEQ beat addresses against the expected burst sequence.
module ahb_slave_mem #(
    parameter int          MEM_AW      = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input logic           CLK_SLAVE,
    input logic           RESET_SLAVE,
    ahb_slave_mem_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << MEM_AW);
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [31:0] mem_q [0:(1<<MEM_AW)-1];

    logic              hready, hresp, bad;
    logic [3:0]        wr_be, lanes;
    logic [MEM_AW-1:0] idx;
    logic [31:0]       rd_word;

    assign idx     = MEM_AW'((addr_q - BASE_ADDR) >> 2);
    assign rd_word = mem_q[idx];

`ifdef AHB_SLAVE_BURST_CHECK_EN
    logic [2:0]  burst_q, burst_d;
    logic        exp_vld_q, exp_vld_d;
    logic [31:0] exp_addr, step, wmask;

    // Next beat address of the burst in flight; WRAP bursts fold inside a beats*size aligned window.
    always_comb begin
        step  = 32'd1 << size_q;
        wmask = '0;
        case (burst_q)
            3'd2:    wmask = (step << 2) - 32'd1;
            3'd4:    wmask = (step << 3) - 32'd1;
            3'd6:    wmask = (step << 4) - 32'd1;
            default: wmask = '0;
        endcase
        if (wmask == '0) exp_addr = addr_q + step;
        else             exp_addr = (addr_q & ~wmask) | ((addr_q + step) & wmask);
    end
`endif

    always_comb begin
        bad = ({1'b0, bus.HADDR} < {1'b0, BASE_ADDR}) ||
              ({1'b0, bus.HADDR} >= END_ADDR) ||
              (bus.HSIZE > 3'd2) ||
              (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
              (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
`ifdef AHB_SLAVE_BURST_CHECK_EN
        if (bus.HTRANS == 2'b11 && (!exp_vld_q || bus.HADDR != exp_addr)) bad = 1'b1;
`endif
    end

    always_comb begin
        case (size_q)
            3'd0:    lanes = 4'b0001 << addr_q[1:0];
            3'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        hrdata_d = hrdata_q;
        hready   = 1'b1;
        hresp    = 1'b0;
        wr_be    = 4'b0000;
`ifdef AHB_SLAVE_BURST_CHECK_EN
        burst_d   = burst_q;
        exp_vld_d = exp_vld_q;
`endif
        case (state_q)
            S_WAIT: begin
                hready = 1'b0;
                if (cnt_q <= 4'd1) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DATA: begin
                if (write_q) wr_be    = lanes;
                else         hrdata_d = rd_word;
            end
            S_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2:  hresp = 1'b1;
            S_IDLE:  ;
            default: state_d = S_IDLE;
        endcase

        // Any ready cycle closes the current phase and may open the next one (pipelined accept).
        if (hready) begin
            state_d = S_IDLE;
`ifdef AHB_SLAVE_BURST_CHECK_EN
            if (!bus.HSEL || bus.HTRANS == 2'b00) exp_vld_d = 1'b0;
`endif
            if (bus.HSEL && bus.HTRANS[1]) begin
                addr_d  = bus.HADDR;
                write_d = bus.HWRITE;
                size_d  = bus.HSIZE;
                cnt_d   = WS;
`ifdef AHB_SLAVE_BURST_CHECK_EN
                burst_d   = bus.HBURST;
                exp_vld_d = !bad;
`endif
                if (bad)           state_d = S_ERR1;
                else if (WS != '0) state_d = S_WAIT;
                else               state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge CLK_SLAVE or posedge RESET_SLAVE) begin
        if (RESET_SLAVE) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            hrdata_q <= '0;
`ifdef AHB_SLAVE_BURST_CHECK_EN
            burst_q   <= '0;
            exp_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hrdata_q <= hrdata_d;
`ifdef AHB_SLAVE_BURST_CHECK_EN
            burst_q   <= burst_d;
            exp_vld_q <= exp_vld_d;
`endif
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so no write can land.
    always_ff @(posedge CLK_SLAVE) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = (state_q == S_DATA && !write_q) ? rd_word : hrdata_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait and one three-wait-state instance.
module tb_ahb_slave_mem;
`ifdef AHB_SLAVE_BURST_CHECK_EN
    localparam logic BCHK = 1'b1;
`else
    localparam logic BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel3 = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hburst = '0;
    logic [31:0] hwdata = '0;
    logic        hready, hresp;
    logic [31:0] hrdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ahb_slave_mem_if if0 ();
    ahb_slave_mem_if if3 ();

    assign if0.HSEL = hsel & ~sel3;
    assign if3.HSEL = hsel & sel3;
    assign {if0.HADDR, if0.HWRITE, if0.HSIZE, if0.HTRANS, if0.HBURST, if0.HWDATA} =
           {haddr, hwrite, hsize, htrans, hburst, hwdata};
    assign {if3.HADDR, if3.HWRITE, if3.HSIZE, if3.HTRANS, if3.HBURST, if3.HWDATA} =
           {haddr, hwrite, hsize, htrans, hburst, hwdata};
    assign hready = sel3 ? if3.HREADY : if0.HREADY;
    assign hresp  = sel3 ? if3.HRESP  : if0.HRESP;
    assign hrdata = sel3 ? if3.HRDATA : if0.HRDATA;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (.CLK_SLAVE(clk), .RESET_SLAVE(rst), .bus(if0));
    ahb_slave_mem #(.WAIT_STATES(3)) u_dut3 (.CLK_SLAVE(clk), .RESET_SLAVE(rst), .bus(if3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single transfer: address phase, then data phase until HREADY (bounded).
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int lo, output logic resp_lo, output logic resp_fin);
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; hburst = 3'd0; hsel = 1'b1;
        cyc();
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        lo = 0; resp_lo = 1'b0; rd = '0; resp_fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hready) begin
                rd = hrdata; resp_fin = hresp;
                break;
            end
            lo++;
            resp_lo = resp_lo | hresp;
            cyc();
        end
        cyc();
    endtask

    task automatic do_wr(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d, input int exp_lo);
        logic [31:0] rd; int lo; logic rl, rf;
        xfer(a, 1'b1, sz, d, rd, lo, rl, rf);
        check({tag, "_waits"}, 32'(lo), 32'(exp_lo));
        check({tag, "_resp"}, {31'd0, rf | rl}, 32'd0);
    endtask

    task automatic do_rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input int exp_lo);
        logic [31:0] rd; int lo; logic rl, rf;
        xfer(a, 1'b0, 3'd2, 32'h0, rd, lo, rl, rf);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_waits"}, 32'(lo), 32'(exp_lo));
        check({tag, "_resp"}, {31'd0, rf | rl}, 32'd0);
    endtask

    task automatic do_err(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        logic [31:0] rd; int lo; logic rl, rf;
        xfer(a, wr, sz, 32'hFFFF_FFFF, rd, lo, rl, rf);
        check({tag, "_lowcycles"}, 32'(lo), 32'd1);
        check({tag, "_resp1"}, {31'd0, rl}, 32'd1);
        check({tag, "_resp2"}, {31'd0, rf}, 32'd1);
    endtask

    // Pipelined WRAP4 word write burst with data = 0xB000_0000 | address.
    task automatic burst4(input string tag, input logic [31:0] a3, input logic exp_err);
        logic [31:0] addrs [4];
        addrs = '{32'h38, 32'h3C, 32'h30, a3};
        haddr = addrs[0]; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hburst = 3'd2; hsel = 1'b1;
        cyc();
        for (int i = 1; i < 4; i++) begin
            hwdata = 32'hB000_0000 | addrs[i-1];
            haddr = addrs[i]; htrans = 2'b11;
            @(negedge clk);
            check($sformatf("%s_beat%0d_rdy", tag, i - 1), {31'd0, hready}, 32'd1);
            check($sformatf("%s_beat%0d_resp", tag, i - 1), {31'd0, hresp}, 32'd0);
            cyc();
        end
        hwdata = 32'hB000_0000 | addrs[3]; hsel = 1'b0; htrans = 2'b00; hburst = 3'd0;
        @(negedge clk);
        check({tag, "_beat3_rdy"}, {31'd0, hready}, {31'd0, ~exp_err});
        check({tag, "_beat3_resp"}, {31'd0, hresp}, {31'd0, exp_err});
        cyc();
        if (exp_err) begin
            @(negedge clk);
            check({tag, "_beat3_err2_rdy"}, {31'd0, hready}, 32'd1);
            check({tag, "_beat3_err2_resp"}, {31'd0, hresp}, 32'd1);
            cyc();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hready", {31'd0, hready}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Make HRDATA non-zero, then reset in the middle of a write burst data phase.
        do_wr("seed0", 32'h00, 3'd2, 32'h1234_5678, 0);
        do_rd("seed0_rd", 32'h00, 32'h1234_5678, 0);
        haddr = 32'h00; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hburst = 3'd1; hsel = 1'b1;
        cyc();
        hwdata = 32'h0BAD_0BAD; haddr = 32'h04; htrans = 2'b11;
        #2 rst = 1'b1;
        #1;
        check("midrst_hready", {31'd0, hready}, 32'd1);
        check("midrst_hresp", {31'd0, hresp}, 32'd0);
        check("midrst_hrdata", hrdata, 32'd0);
        cyc();
        check("midrst_hold_hready", {31'd0, hready}, 32'd1);
        check("midrst_hold_hrdata", hrdata, 32'd0);
        hsel = 1'b0; htrans = 2'b00; hburst = 3'd0;
        rst = 1'b0;
        cyc();
        do_rd("write_discarded", 32'h00, 32'h1234_5678, 0);

        do_wr("wr_10", 32'h10, 3'd2, 32'hDEAD_BEEF, 0);
        do_rd("rd_10", 32'h10, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        check("hrdata_hold", hrdata, 32'hDEAD_BEEF);
        cyc();

        do_wr("wr_word", 32'h10, 3'd2, 32'h1122_3344, 0);
        do_wr("wr_byte", 32'h13, 3'd0, 32'hAA55_6677, 0);
        do_rd("rd_byte", 32'h10, 32'hAA22_3344, 0);
        do_wr("wr_half", 32'h10, 3'd1, 32'h9999_CAFE, 0);
        do_rd("rd_half", 32'h10, 32'hAA22_CAFE, 0);

        sel3 = 1'b1;
        do_wr("ws_wr", 32'h04, 3'd2, 32'hA5A5_0004, 3);
        do_rd("ws_rd", 32'h04, 32'hA5A5_0004, 3);
        @(negedge clk);
        check("ws_hrdata_hold", hrdata, 32'hA5A5_0004);
        cyc();
        sel3 = 1'b0;

        do_err("oor_wr", 32'h100, 1'b1, 3'd2);
        do_rd("oor_mem_unchanged", 32'h00, 32'h1234_5678, 0);
        do_err("misalign_word", 32'h02, 1'b0, 3'd2);
        do_err("misalign_half", 32'h11, 1'b0, 3'd1);
        do_err("bad_size", 32'h00, 1'b0, 3'd3);

        do_wr("b2b_seed", 32'h20, 3'd2, 32'h77, 0);
        haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hburst = 3'd0; hsel = 1'b1;
        cyc();
        hwdata = 32'h5; hwrite = 1'b0;
        @(negedge clk);
        check("b2b_wr_rdy", {31'd0, hready}, 32'd1);
        cyc();
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b2b_rd_rdy", {31'd0, hready}, 32'd1);
        check("b2b_rd_data", hrdata, 32'h5);
        check("b2b_rd_resp", {31'd0, hresp}, 32'd0);
        cyc();

        burst4("wrap_ok", 32'h34, 1'b0);
        do_rd("wrap_ok_rd30", 32'h30, 32'hB000_0030, 0);
        do_rd("wrap_ok_rd3c", 32'h3C, 32'hB000_003C, 0);
        do_wr("pre40", 32'h40, 3'd2, 32'h4040_4040, 0);
        burst4("wrap_bad", 32'h40, BCHK);
        do_rd("wrap_bad_rd40", 32'h40, BCHK ? 32'h4040_4040 : 32'hB000_0040, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Single-port, memory-backed AHB slave directly downstream of the team's AHB master.
- Consumes HADDR/HWRITE/HSIZE/HWDATA plus transfer-type and burst qualifiers.
- Returns HREADY/HRDATA/HRESP to the master.
- Supports programmable wait states, byte/half/word writes, and two-cycle ERROR responses for illegal accesses.

Parameters:
- MEM_AW, 6: word-address width; depth = 2^MEM_AW 32-bit words (default 64 words = 256 bytes).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*2^MEM_AW.
- WAIT_STATES, 0: HREADY-low cycles inserted per data phase (0..15).

Ports:
- CLK_SLAVE  input  1  rising-edge clock.
- RESET_SLAVE  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address (address phase).
- HWRITE  input  1  1 = write, 0 = read (address phase).
- HSIZE  input  3  0 = byte, 1 = half, 2 = word; 3..7 illegal.
- HTRANS  input  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HBURST  input  3  0 = SINGLE, 1 = INCR, 2 = WRAP4, 3 = INCR4, 4 = WRAP8, 5 = INCR8, 6 = WRAP16, 7 = INCR16.
- HWDATA  input  32  write data (data phase).
- HREADY  output  1  transfer done / slave ready.
- HRDATA  output  32  read data (valid when HREADY = 1 in a read data phase).
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, RESET_SLAVE = 1):
  - HREADY = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, wait counter = 0.
  - Any pending write is discarded; memory contents are not reset.
  - Outputs hold the reset values for as long as reset is asserted.
- Address phase is accepted on a rising edge when HREADY = 1, HSEL = 1 and HTRANS is NONSEQ or SEQ.
  - On acceptance, HADDR, HWRITE, HSIZE, HBURST and the error decision are registered.
  - IDLE or BUSY, or HSEL = 0, yields a zero-wait OKAY data phase with no memory access.
- Error decision:
  - out of range: HADDR < BASE_ADDR or HADDR >= BASE_ADDR + 4*2^MEM_AW;
  - HSIZE > 2;
  - half transfer with HADDR[0] = 1;
  - word transfer with HADDR[1:0] != 0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: accepted legal transfer -> WAIT if WAIT_STATES > 0, else DATA. Accepted illegal transfer -> ERR1. Otherwise stay in IDLE.
  - WAIT: HREADY = 0; counter loaded with WAIT_STATES on accept and decremented each cycle; goes to DATA when the counter reaches 1.
  - DATA: HREADY = 1, HRESP = 0.
    - Read: HRDATA = mem[addr_q word index], full word, all lanes.
    - Write: HWDATA lanes are written at the closing edge.
    - A new transfer can be accepted on the same edge (pipelined); next state follows the IDLE rules, otherwise IDLE.
  - ERR1: HREADY = 0, HRESP = 1, no memory access -> ERR2.
  - ERR2: HREADY = 1, HRESP = 1; a new transfer may be accepted (same rules as IDLE).
- Byte lanes for a write, keyed on addr_q[1:0]:
  - byte: lane addr_q[1:0];
  - half: lanes {addr_q[1], 0} and {addr_q[1], 1};
  - word: all four lanes.
- Read-after-write to the same word in back-to-back transfers returns the new data (the write commits at the edge that starts the read data phase).
- HRDATA holds its last value outside read data phases.
- SEQ beats are not burst-checked unless the optional feature is enabled.
- Word index = (addr - BASE_ADDR) >> 2, truncated to MEM_AW bits.

Optional Feature:
- Macro: AHB_SLAVE_BURST_CHECK_EN.
- With the macro defined:
  - The slave records the expected next address for each beat:
    - INCR*: previous address + (1 << size);
    - WRAP4/8/16: increment wrapped within a (beats << size)-byte aligned boundary.
  - A SEQ beat whose HADDR differs from the expected address, or a SEQ with no preceding NONSEQ, takes the ERR1/ERR2 path.
- Without the macro: SEQ is treated exactly like NONSEQ and no expected-address logic exists.

Test Plan:
- Reset and word write/read: reset asserted mid-burst -> HREADY = 1, HRESP = 0, HRDATA = 0 immediately. Then word write 32'hDEADBEEF @ 0x10, read @ 0x10, WAIT_STATES = 0 -> HRDATA = 32'hDEADBEEF, each transfer completes in 1 data cycle.
- Byte write: write byte 8'hAA @ 0x13 over word 32'h11223344 @ 0x10 -> read returns 32'hAA223344.
- Wait states: WAIT_STATES = 3, read @ 0x04 -> HREADY low 3 cycles, high on the 4th with data; HRESP = 0 throughout.
- Out-of-range: write @ 0x100 with MEM_AW = 6 -> HREADY 0/HRESP 1, then HREADY 1/HRESP 1; memory unchanged.
- Misaligned: word read @ 0x02 -> same two-cycle ERROR response.
- Back-to-back and bursts:
  - Write 0x5 @ 0x20 immediately followed by read @ 0x20 -> read returns 0x5.
  - With AHB_SLAVE_BURST_CHECK_EN, WRAP4 word burst 0x38, 0x3C, 0x30, 0x34 -> all OKAY.
  - Same burst with 4th beat @ 0x40 -> ERROR on that beat only.
